// File: rtl/shared_mailbox_pkg.sv
// rtl/shared_mailbox_pkg.sv - register offsets, semaphore owner codes and doorbell field helpers
package shared_mailbox_pkg;

  localparam int OFF_HSTAT = 0;
  localparam int OFF_CSTAT = 1;
  localparam int OFF_H2C   = 2;
  localparam int OFF_C2H   = 3;
  localparam int OFF_SEM   = 4;

  typedef enum logic [1:0] {
    SEM_FREE   = 2'd0,
    SEM_HOST   = 2'd1,
    SEM_CLIENT = 2'd2
  } sem_owner_e;

  function automatic int db_pend_bit(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int db_ovr_bit(input int data_w);
    return data_w - 2;
  endfunction

  function automatic int db_msg_w(input int data_w);
    return data_w - 2;
  endfunction

endpackage

// File: rtl/shared_dp_ram.sv
// rtl/shared_dp_ram.sv - true dual-port read-first RAM, port a wins a same-word write collision
module shared_dp_ram #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Port a is written last so its data survives a collision on the same word.
  always_ff @(posedge clk) begin
    a_dout <= mem[a_addr];
    b_dout <= mem[b_addr];
    if (b_we) mem[b_addr] <= b_din;
    if (a_we) mem[a_addr] <= a_din;
  end

endmodule

// File: rtl/shared_mailbox.sv
// rtl/shared_mailbox.sv - host/client shared RAM, status registers and doorbells
// Optional hardware semaphore at REG_BASE+4 enabled by macro SHARED_MAILBOX_SEM_EN.
module shared_mailbox
  import shared_mailbox_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 256,
  parameter int REG_BASE  = 'h100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic [DATA_W-1:0] host_dout,
  input  logic              client_we,
  input  logic [ADDR_W-1:0] client_addr,
  input  logic [DATA_W-1:0] client_din,
  output logic [DATA_W-1:0] client_dout,
  output logic              host_irq,
  output logic              client_irq
);

  localparam int WA_W   = ADDR_W - 2;
  localparam int RAM_AW = $clog2(MEM_DEPTH);
  localparam int MSG_W  = db_msg_w(DATA_W);

  localparam logic [WA_W-1:0] MEM_LIM = WA_W'(MEM_DEPTH);
  localparam logic [WA_W-1:0] A_HSTAT = WA_W'(REG_BASE + OFF_HSTAT);
  localparam logic [WA_W-1:0] A_CSTAT = WA_W'(REG_BASE + OFF_CSTAT);
  localparam logic [WA_W-1:0] A_H2C   = WA_W'(REG_BASE + OFF_H2C);
  localparam logic [WA_W-1:0] A_C2H   = WA_W'(REG_BASE + OFF_C2H);
  localparam logic [WA_W-1:0] A_SEM   = WA_W'(REG_BASE + OFF_SEM);

  logic [WA_W-1:0] host_wa, client_wa;
  logic host_ram, host_hstat, host_cstat, host_h2c, host_c2h, host_sem;
  logic client_ram, client_hstat, client_cstat, client_h2c, client_c2h, client_sem;
  logic addr_unused;

  assign host_wa    = host_addr[ADDR_W-1:2];
  assign client_wa  = client_addr[ADDR_W-1:2];
  assign addr_unused = ^{host_addr[1:0], client_addr[1:0]};

  assign host_ram     = host_wa < MEM_LIM;
  assign host_hstat   = host_wa == A_HSTAT;
  assign host_cstat   = host_wa == A_CSTAT;
  assign host_h2c     = host_wa == A_H2C;
  assign host_c2h     = host_wa == A_C2H;
  assign host_sem     = host_wa == A_SEM;
  assign client_ram   = client_wa < MEM_LIM;
  assign client_hstat = client_wa == A_HSTAT;
  assign client_cstat = client_wa == A_CSTAT;
  assign client_h2c   = client_wa == A_H2C;
  assign client_c2h   = client_wa == A_C2H;
  assign client_sem   = client_wa == A_SEM;

  logic [DATA_W-1:0] host_ram_q, client_ram_q;

  shared_dp_ram #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk    (clk),
    .a_we   (host_we & host_ram),
    .a_addr (host_wa[RAM_AW-1:0]),
    .a_din  (host_din),
    .a_dout (host_ram_q),
    .b_we   (client_we & client_ram),
    .b_addr (client_wa[RAM_AW-1:0]),
    .b_din  (client_din),
    .b_dout (client_ram_q)
  );

  logic [DATA_W-1:0] hstat_q, cstat_q;
  logic              h2c_pend, h2c_ovr, c2h_pend, c2h_ovr;
  logic [MSG_W-1:0]  h2c_msg, c2h_msg;
  logic              h2c_send, h2c_ack, c2h_send, c2h_ack;

  assign h2c_send = host_we & host_h2c;
  assign h2c_ack  = client_we & client_h2c;
  assign c2h_send = client_we & client_c2h;
  assign c2h_ack  = host_we & host_c2h;

  // A same-cycle ack clears the channel before the new message lands, so overrun stays 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      hstat_q  <= '0;
      cstat_q  <= '0;
      h2c_pend <= 1'b0;
      h2c_ovr  <= 1'b0;
      h2c_msg  <= '0;
      c2h_pend <= 1'b0;
      c2h_ovr  <= 1'b0;
      c2h_msg  <= '0;
    end else begin
      if (host_we && host_hstat)     hstat_q <= host_din;
      if (client_we && client_cstat) cstat_q <= client_din;
      if (h2c_ack) begin
        h2c_pend <= 1'b0;
        h2c_ovr  <= 1'b0;
      end
      if (h2c_send) begin
        h2c_pend <= 1'b1;
        h2c_ovr  <= ~h2c_ack & (h2c_ovr | h2c_pend);
        h2c_msg  <= host_din[MSG_W-1:0];
      end
      if (c2h_ack) begin
        c2h_pend <= 1'b0;
        c2h_ovr  <= 1'b0;
      end
      if (c2h_send) begin
        c2h_pend <= 1'b1;
        c2h_ovr  <= ~c2h_ack & (c2h_ovr | c2h_pend);
        c2h_msg  <= client_din[MSG_W-1:0];
      end
    end
  end

  assign client_irq = h2c_pend;
  assign host_irq   = c2h_pend;

  logic [DATA_W-1:0] sem_word;

`ifdef SHARED_MAILBOX_SEM_EN
  sem_owner_e sem_q, sem_d;

  always_ff @(posedge clk) begin
    if (reset) sem_q <= SEM_FREE;
    else       sem_q <= sem_d;
  end

  // Releases resolve before requests; host wins a tie on a free semaphore.
  always_comb begin
    sem_d = sem_q;
    if (host_we && host_sem && !host_din[0] && sem_d == SEM_HOST)           sem_d = SEM_FREE;
    if (client_we && client_sem && !client_din[0] && sem_d == SEM_CLIENT)   sem_d = SEM_FREE;
    if (sem_d == SEM_FREE) begin
      if (host_we && host_sem && host_din[0])             sem_d = SEM_HOST;
      else if (client_we && client_sem && client_din[0])  sem_d = SEM_CLIENT;
    end
  end

  assign sem_word = DATA_W'(sem_q);
`else
  logic sem_unused;
  assign sem_unused = host_sem | client_sem;
  assign sem_word   = '0;
`endif

  logic [DATA_W-1:0] h2c_word, c2h_word, host_rd, client_rd;
  logic [DATA_W-1:0] host_reg_q, client_reg_q;
  logic              host_sel_ram_q, client_sel_ram_q;

  assign h2c_word = {h2c_pend, h2c_ovr, h2c_msg};
  assign c2h_word = {c2h_pend, c2h_ovr, c2h_msg};

  assign host_rd = ({DATA_W{host_hstat}} & hstat_q) | ({DATA_W{host_cstat}} & cstat_q)
                 | ({DATA_W{host_h2c}} & h2c_word)  | ({DATA_W{host_c2h}} & c2h_word)
                 | ({DATA_W{host_sem}} & sem_word);
  assign client_rd = ({DATA_W{client_hstat}} & hstat_q) | ({DATA_W{client_cstat}} & cstat_q)
                   | ({DATA_W{client_h2c}} & h2c_word)  | ({DATA_W{client_c2h}} & c2h_word)
                   | ({DATA_W{client_sem}} & sem_word);

  // Register path is sampled alongside the RAM read so both sources share one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_reg_q       <= '0;
      client_reg_q     <= '0;
      host_sel_ram_q   <= 1'b0;
      client_sel_ram_q <= 1'b0;
    end else begin
      host_reg_q       <= host_rd;
      client_reg_q     <= client_rd;
      host_sel_ram_q   <= host_ram;
      client_sel_ram_q <= client_ram;
    end
  end

  assign host_dout   = host_sel_ram_q ? host_ram_q : host_reg_q;
  assign client_dout = client_sel_ram_q ? client_ram_q : client_reg_q;

endmodule
